ahb_lite_dma_master: RTL and testbench
======================================

// Module: ahb_lite_dma_master
// PURPOSE
//  AHB-Lite bus master (initiator side of the SoC bus) that copies word blocks without CPU load.
//  Sits beside the Cortex-M0 as a second master and feeds the AHB-Lite interconnect.
//  Typical use: RAM_DATA -> LCD/user register (fixed dst) or RAMCODE -> RAMDATA block copy.
//  Signals completion with a one-cycle IRQ pulse and reports bus errors.
// PARAMETERS
//  LEN_W    16           width of word-count register; max block = 2^LEN_W-1 words
//  HPROT_V  4'b0011      constant HPROT value driven on every transfer (data, privileged)
// PORTS
//  clk         in   1      system/AHB clock
//  RSTn        in   1      asynchronous, active-low reset
//  cfg_src     in   32     source byte address; bits[1:0] ignored (forced 0)
//  cfg_dst     in   32     destination byte address; bits[1:0] ignored (forced 0)
//  cfg_len     in   LEN_W  number of 32-bit words to copy
//  cfg_src_inc in   1      1: src += 4 per word, 0: fixed src
//  cfg_dst_inc in   1      1: dst += 4 per word, 0: fixed dst (peripheral FIFO/register)
//  start       in   1      1-cycle pulse; cfg_* sampled on this cycle
//  abort       in   1      level/pulse; stop at next word boundary
//  busy        out  1      1 from cycle after accepted start until DONE/ERR exit
//  done_irq    out  1      1-cycle pulse at end of block (normal, abort or error)
//  err         out  1      sticky; set on HRESP error, cleared by next accepted start
//  HADDR       out  32     AHB address
//  HTRANS      out  2      IDLE=2'b00 or NONSEQ=2'b10 only
//  HWRITE      out  1      AHB direction
//  HSIZE       out  3      constant 3'b010 (word)
//  HBURST      out  3      constant 3'b000 (SINGLE)
//  HPROT       out  4      constant HPROT_V
//  HMASTLOCK   out  1      constant 0
//  HWDATA      out  32     write data (valid in WR_DATA)
//  HRDATA      in   32     read data
//  HREADY      in   1      transfer-complete / wait-state from interconnect
//  HRESP       in   1      0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: state=IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done_irq=0, err=0, counters 0.
//  FSM: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE.
//   IDLE: start & cfg_len!=0 -> RD_ADDR, latch src/dst/len/inc, clear err. start & cfg_len==0 -> DONE (no bus traffic).
//   RD_ADDR: HTRANS=NONSEQ, HADDR=src, HWRITE=0; on HREADY=1 -> RD_DATA, else hold all address signals.
//   RD_DATA: HTRANS=IDLE; HREADY=1 & HRESP=0 -> capture HRDATA into buffer, -> WR_ADDR.
//   WR_ADDR: HTRANS=NONSEQ, HADDR=dst, HWRITE=1; on HREADY=1 -> WR_DATA.
//   WR_DATA: HTRANS=IDLE, HWDATA=buffer held stable until HREADY=1; then len-=1, src/dst += 4 if inc;
//            len==0 or abort seen -> DONE, else -> RD_ADDR.
//   DONE: done_irq=1 for exactly this cycle, busy=0 next cycle -> IDLE.
//  Throughput: 4 cycles/word with zero wait states; each wait state adds 1 cycle.
//  Error: HRESP=1 & HREADY=1 in RD_DATA or WR_DATA -> err=1, -> DONE (remaining words skipped; no write of failed read).
//   First error cycle (HRESP=1, HREADY=0) needs no action since HTRANS is already IDLE.
//  abort: latched (sticky until DONE); never truncates an AHB transfer in progress; checked only at WR_DATA completion.
//  start while busy: ignored, cfg_* not resampled. start & abort same cycle in IDLE: start wins, abort discarded.
//  Address arithmetic modulo 2^32 (0xFFFFFFFC + 4 -> 0x00000000); bits[1:0] of HADDR always 0.
//  RSTn asserted mid-transfer: immediate return to reset values; no done_irq.
// TESTING
//  src=0x20000000,dst=0x20000100,len=4,both inc, HREADY=1 -> 4 reads/4 writes, done_irq at cycle 17 after start, data matches.
//  Same block with HREADY low 2 cycles in every data phase -> HWDATA/HADDR stable during waits, 32 cycles+1 to done.
//  dst_inc=0,dst=0x40000010,len=3 -> all 3 writes to 0x40000010 in order; src 0x..00,0x..04,0x..08.
//  HRESP error (2-cycle) on 2nd read -> err=1, done_irq, exactly 1 write issued; next start clears err.
//  cfg_len=0 -> done_irq 1 cycle after start, HTRANS stays IDLE; start during busy -> no effect.
//  abort during 2nd word's RD_ADDR wait of len=8 -> 2nd word completes, DONE, 2 writes total.

Source files
------------

// File: rtl/ahb_lite_dma_master.sv
// AHB-Lite DMA master: copies a block of 32-bit words from src to dst using
// single NONSEQ transfers, one read then one write per word.
module ahb_lite_dma_master #(
    parameter int unsigned LEN_W   = 16,
    parameter logic [3:0]  HPROT_V = 4'b0011
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic [31:0]      cfg_src,
    input  logic [31:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_src_inc,
    input  logic             cfg_dst_inc,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done_irq,
    output logic             err,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t           state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             src_inc;
    logic             dst_inc;
    logic             abort_seen;
    logic [31:0]      src_next;
    logic [31:0]      dst_next;
    logic             last_word;

    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_V;
    assign HMASTLOCK = 1'b0;

    assign src_next  = src + {29'd0, src_inc, 2'b00};
    assign dst_next  = dst + {29'd0, dst_inc, 2'b00};
    // abort is only honoured here, so a pending transfer is never cut short
    assign last_word = (len == LEN_W'(1)) || abort_seen || abort;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            len        <= '0;
            src_inc    <= 1'b0;
            dst_inc    <= 1'b0;
            abort_seen <= 1'b0;
            busy       <= 1'b0;
            done_irq   <= 1'b0;
            err        <= 1'b0;
            HADDR      <= '0;
            HTRANS     <= TR_IDLE;
            HWRITE     <= 1'b0;
            HWDATA     <= '0;
        end else begin
            done_irq <= 1'b0;
            if (state != IDLE && abort) begin
                abort_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        abort_seen <= 1'b0;
                        if (cfg_len != '0) begin
                            src     <= cfg_src & 32'hFFFF_FFFC;
                            dst     <= cfg_dst & 32'hFFFF_FFFC;
                            len     <= cfg_len;
                            src_inc <= cfg_src_inc;
                            dst_inc <= cfg_dst_inc;
                            HADDR   <= cfg_src & 32'hFFFF_FFFC;
                            HTRANS  <= TR_NONSEQ;
                            HWRITE  <= 1'b0;
                            state   <= RD_ADDR;
                        end else begin
                            done_irq <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                RD_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= TR_IDLE;
                        state  <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err      <= 1'b1;
                            done_irq <= 1'b1;
                            state    <= DONE;
                        end else begin
                            HWDATA <= HRDATA;
                            HADDR  <= dst;
                            HTRANS <= TR_NONSEQ;
                            HWRITE <= 1'b1;
                            state  <= WR_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= TR_IDLE;
                        state  <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err      <= 1'b1;
                            done_irq <= 1'b1;
                            state    <= DONE;
                        end else begin
                            len <= len - LEN_W'(1);
                            src <= src_next;
                            dst <= dst_next;
                            if (last_word) begin
                                done_irq <= 1'b1;
                                state    <= DONE;
                            end else begin
                                HADDR  <= src_next;
                                HTRANS <= TR_NONSEQ;
                                HWRITE <= 1'b0;
                                state  <= RD_ADDR;
                            end
                        end
                    end
                end
                DONE: begin
                    busy       <= 1'b0;
                    abort_seen <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_dma_master.sv
// Randomised bench for ahb_lite_dma_master: behavioural AHB slave with memory,
// wait-state and error injection, checked against a block-copy reference model.
module tb_ahb_lite_dma_master;

    logic        clk = 1'b0;
    logic        RSTn;
    logic [31:0] cfg_src, cfg_dst;
    logic [15:0] cfg_len;
    logic        cfg_src_inc, cfg_dst_inc, start, abort;
    logic        busy, done_irq, err;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    ahb_lite_dma_master #(.LEN_W(16), .HPROT_V(4'b0011)) dut (
        .clk(clk), .RSTn(RSTn), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
        .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc), .start(start), .abort(abort),
        .busy(busy), .done_irq(done_irq), .err(err), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // slave configuration and observation
    int waits = 0, addr_waits = 0, err_idx = -1;
    int aw_left = 0, rd_acc = 0, phase_cyc = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, viol = 0, nseq_cnt = 0;
    logic [31:0] mem [logic [31:0]];
    logic [63:0] wr_q[$], exp_wr[$];
    logic [31:0] rd_q[$], exp_rd[$];
    bit          dp_active = 0, dp_write = 0, dp_err = 0, wd_valid = 0;
    logic [31:0] dp_addr, dp_wdata;
    logic [1:0]  s_htrans, p_htrans = 2'b00;
    logic [31:0] s_haddr, s_hwdata, p_haddr = '0;
    logic        s_hwrite, s_hready, s_hresp, p_hwrite = 1'b0, p_hready = 1'b1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_val(a);
    endfunction

    // Reference: n words, each read from src_i and written to dst_i unchanged
    task automatic build_model(input logic [31:0] s, input logic [31:0] d, input int n,
                               input bit si, input bit di);
        logic [31:0] sa, da;
        exp_wr.delete(); exp_rd.delete();
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(sa);
            exp_wr.push_back({da, init_val(sa)});
            if (si) sa = sa + 32'd4;
            if (di) da = da + 32'd4;
        end
    endtask

    function automatic int q_diff();
        int e = 0;
        if (wr_q.size() != exp_wr.size() || rd_q.size() != exp_rd.size()) return 1000;
        foreach (wr_q[i]) if (wr_q[i] !== exp_wr[i]) e++;
        foreach (rd_q[i]) if (rd_q[i] !== exp_rd[i]) e++;
        return e;
    endfunction

    initial begin : ahb_slave
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        forever begin
            @(posedge clk);
            s_htrans = HTRANS; s_haddr = HADDR; s_hwrite = HWRITE; s_hwdata = HWDATA;
            s_hready = HREADY; s_hresp = HRESP;
            if (done_irq) begin done_cnt++; done_cyc = cyc; end
            cyc++;
            if (!RSTn) begin
                dp_active = 0; p_htrans = 2'b00; p_hready = 1'b1;
            end else begin
                if (s_htrans == 2'b10) nseq_cnt++;
                if (s_htrans != 2'b00 && s_htrans != 2'b10) viol++;
                if (dp_active && dp_write) begin
                    if (!wd_valid) begin dp_wdata = s_hwdata; wd_valid = 1; end
                    else if (s_hwdata !== dp_wdata) viol++;
                end
                if (p_htrans == 2'b10 && !p_hready &&
                    (s_htrans != 2'b10 || s_haddr !== p_haddr || s_hwrite !== p_hwrite)) viol++;
                if (dp_active && s_hready) begin
                    if (!s_hresp) begin
                        if (dp_write) begin
                            wr_q.push_back({dp_addr, s_hwdata});
                            mem[dp_addr] = s_hwdata;
                        end else rd_q.push_back(dp_addr);
                    end
                    dp_active = 0;
                end
                if (s_htrans == 2'b10 && s_hready) begin
                    if (s_haddr[1:0] != 2'b00) viol++;
                    dp_active = 1; dp_addr = s_haddr; dp_write = s_hwrite;
                    phase_cyc = 0; wd_valid = 0;
                    dp_err = !s_hwrite && (rd_acc == err_idx);
                    if (!s_hwrite) rd_acc++;
                    aw_left = addr_waits;
                end
                p_htrans = s_htrans; p_haddr = s_haddr; p_hwrite = s_hwrite; p_hready = s_hready;
            end
            #1;
            if (!RSTn || !dp_active) begin
                HRESP = 1'b0;
                if (RSTn && HTRANS == 2'b10 && aw_left > 0) begin
                    HREADY = 1'b0; aw_left--;
                end else HREADY = 1'b1;
            end else if (dp_err) begin
                HRESP = 1'b1; HREADY = (phase_cyc != 0);
            end else begin
                HRESP = 1'b0;
                if (phase_cyc < waits) HREADY = 1'b0;
                else begin
                    HREADY = 1'b1;
                    if (!dp_write) HRDATA = mem_rd(dp_addr);
                end
            end
            if (dp_active) phase_cyc++;
        end
    end

    // mode: 0 plain, 1 abort during 2nd read address phase, 2 start while busy, 3 abort with start
    task automatic run_dma(input logic [31:0] s, input logic [31:0] d, input int n,
                           input bit si, input bit di, input int mode,
                           output int delta, output int pulses, output logic busy1);
        int d0, sc;
        bit fired;
        d0 = done_cnt; fired = 0;
        wr_q.delete(); rd_q.delete(); rd_acc = 0; aw_left = addr_waits;
        cfg_src = s; cfg_dst = d; cfg_len = 16'(n); cfg_src_inc = si; cfg_dst_inc = di;
        abort = (mode == 3);
        start = 1'b1; sc = cyc;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; busy1 = busy;
        delta = -1;
        for (int i = 0; i < 600; i++) begin
            if (done_cnt != d0) break;
            abort = 1'b0; start = 1'b0;
            if (mode == 1 && !fired && rd_acc == 1 && HTRANS == 2'b10 && !HWRITE) begin
                abort = 1'b1; fired = 1;
            end
            if (mode == 2 && i == 5) begin
                start = 1'b1; cfg_src = 32'h2000_8000; cfg_len = 16'd1; cfg_dst_inc = ~di;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0;
        if (done_cnt != d0) delta = done_cyc - sc;
        repeat (2) begin @(posedge clk); #1; end
        pulses = done_cnt - d0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; start = 0; abort = 0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
        cfg_src_inc = 0; cfg_dst_inc = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({HTRANS, HWRITE, busy, done_irq, err} !== 6'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {HTRANS, HWRITE, busy, done_irq, err}); end
        checks++; if (HADDR !== 32'h0 || HWDATA !== 32'h0) begin errors++;
            $display("FAIL reset_bus: HADDR=%h HWDATA=%h want 0", HADDR, HWDATA); end
        checks++; if ({HSIZE, HBURST, HPROT, HMASTLOCK} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin errors++;
            $display("FAIL reset_const: got %b want 01000000110", {HSIZE, HBURST, HPROT, HMASTLOCK}); end
        RSTn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_basic_copy();
        int dl, pl; logic b1;
        waits = 0; addr_waits = 0; err_idx = -1;
        build_model(32'h2000_0000, 32'h2000_0100, 4, 1, 1);
        run_dma(32'h2000_0000, 32'h2000_0100, 4, 1, 1, 0, dl, pl, b1);
        checks++; if (dl !== 17) begin errors++; $display("FAIL basic_latency: got %0d want 17", dl); end
        checks++; if (q_diff() != 0) begin errors++;
            $display("FAIL basic_data: %0d diffs, writes=%0d want 4", q_diff(), wr_q.size()); end
        checks++; if (pl !== 1 || b1 !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin errors++;
            $display("FAIL basic_flags: pulses=%0d busy1=%b busy=%b err=%b want 1 1 0 0", pl, b1, busy, err); end
    endtask

    task automatic test_wait_states();
        int dl, pl; logic b1;
        waits = 2; addr_waits = 0; err_idx = -1;
        build_model(32'h2000_0000, 32'h2000_0100, 4, 1, 1);
        run_dma(32'h2000_0000, 32'h2000_0100, 4, 1, 1, 0, dl, pl, b1);
        checks++; if (dl !== 33) begin errors++; $display("FAIL wait_latency: got %0d want 33", dl); end
        checks++; if (q_diff() != 0 || viol != 0) begin errors++;
            $display("FAIL wait_data: diffs=%0d stability_violations=%0d want 0 0", q_diff(), viol); end
        waits = 0;
    endtask

    task automatic test_fixed_dst();
        int dl, pl; logic b1;
        build_model(32'h2000_0200, 32'h4000_0010, 3, 1, 0);
        run_dma(32'h2000_0200, 32'h4000_0010, 3, 1, 0, 0, dl, pl, b1);
        checks++; if (q_diff() != 0 || dl !== 13) begin errors++;
            $display("FAIL fixed_dst: diffs=%0d latency=%0d want 0 13", q_diff(), dl); end
    endtask

    task automatic test_error();
        int dl, pl; logic b1;
        err_idx = 1;
        build_model(32'h2000_0300, 32'h3000_0300, 1, 1, 1);
        run_dma(32'h2000_0300, 32'h3000_0300, 4, 1, 1, 0, dl, pl, b1);
        checks++; if (err !== 1'b1 || pl !== 1 || dl !== 8) begin errors++;
            $display("FAIL error_flags: err=%b pulses=%0d latency=%0d want 1 1 8", err, pl, dl); end
        checks++; if (q_diff() != 0) begin errors++;
            $display("FAIL error_writes: writes=%0d want 1", wr_q.size()); end
        err_idx = -1;
        build_model(32'h2000_0400, 32'h3000_0400, 2, 1, 1);
        run_dma(32'h2000_0400, 32'h3000_0400, 2, 1, 1, 0, dl, pl, b1);
        checks++; if (err !== 1'b0 || q_diff() != 0) begin errors++;
            $display("FAIL error_clear: err=%b diffs=%0d want 0 0", err, q_diff()); end
    endtask

    task automatic test_zero_len_and_busy_start();
        int dl, pl, n0; logic b1;
        n0 = nseq_cnt;
        build_model(32'h2000_0500, 32'h3000_0500, 0, 1, 1);
        run_dma(32'h2000_0500, 32'h3000_0500, 0, 1, 1, 0, dl, pl, b1);
        checks++; if (dl !== 1 || pl !== 1 || nseq_cnt != n0) begin errors++;
            $display("FAIL zero_len: latency=%0d pulses=%0d nonseq=%0d want 1 1 0", dl, pl, nseq_cnt - n0); end
        build_model(32'h2000_0600, 32'h3000_0600, 4, 1, 1);
        run_dma(32'h2000_0600, 32'h3000_0600, 4, 1, 1, 2, dl, pl, b1);
        checks++; if (q_diff() != 0 || dl !== 17 || pl !== 1) begin errors++;
            $display("FAIL busy_start: diffs=%0d latency=%0d pulses=%0d want 0 17 1", q_diff(), dl, pl); end
    endtask

    task automatic test_abort();
        int dl, pl; logic b1;
        addr_waits = 2;
        build_model(32'h2000_0700, 32'h3000_0700, 2, 1, 1);
        run_dma(32'h2000_0700, 32'h3000_0700, 8, 1, 1, 1, dl, pl, b1);
        checks++; if (q_diff() != 0 || dl !== 17 || viol != 0) begin errors++;
            $display("FAIL abort_mid: writes=%0d latency=%0d viol=%0d want 2 17 0", wr_q.size(), dl, viol); end
        addr_waits = 0;
        build_model(32'h2000_0800, 32'h3000_0800, 3, 1, 1);
        run_dma(32'h2000_0800, 32'h3000_0800, 3, 1, 1, 3, dl, pl, b1);
        checks++; if (q_diff() != 0 || dl !== 13) begin errors++;
            $display("FAIL abort_with_start: writes=%0d latency=%0d want 3 13", wr_q.size(), dl); end
    endtask

    task automatic test_wrap();
        int dl, pl; logic b1;
        build_model(32'hFFFF_FFFB, 32'h5000_0003, 3, 1, 1);
        run_dma(32'hFFFF_FFFB, 32'h5000_0003, 3, 1, 1, 0, dl, pl, b1);
        checks++; if (q_diff() != 0 || viol != 0) begin errors++;
            $display("FAIL wrap: diffs=%0d viol=%0d want 0 0", q_diff(), viol); end
    endtask

    task automatic test_random();
        int dl, pl, n; logic b1; logic [31:0] s, d; bit si, di;
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(6, 1);
            waits = $urandom_range(2, 0);
            addr_waits = $urandom_range(1, 0);
            si = 1'($urandom_range(1, 0)); di = 1'($urandom_range(1, 0));
            s = 32'h2001_0000 + ($urandom & 32'h0000_FFFF);
            d = 32'h3001_0000 + ($urandom & 32'h0000_FFFF);
            build_model(s, d, n, si, di);
            run_dma(s, d, n, si, di, 0, dl, pl, b1);
            checks++; if (q_diff() != 0 || dl !== 1 + n * (4 + 2 * waits + 2 * addr_waits) || pl !== 1) begin
                errors++;
                $display("FAIL random_%0d: diffs=%0d latency=%0d pulses=%0d want 0 %0d 1", k, q_diff(), dl, pl,
                         1 + n * (4 + 2 * waits + 2 * addr_waits));
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL random_stability: viol=%0d want 0", viol); end
        waits = 0; addr_waits = 0;
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        rd_acc = 0; aw_left = 0;
        cfg_src = 32'h2000_0900; cfg_dst = 32'h3000_0900; cfg_len = 16'd4;
        cfg_src_inc = 1; cfg_dst_inc = 1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 RSTn = 1'b0;
        #1;
        checks++; if ({busy, HTRANS, HWRITE, done_irq} !== 5'b0 || HADDR !== 32'h0) begin errors++;
            $display("FAIL reset_mid: busy=%b HTRANS=%b HWRITE=%b HADDR=%h want 0 00 0 0", busy, HTRANS, HWRITE, HADDR); end
        @(posedge clk); #1; RSTn = 1'b1;
        repeat (30) begin @(posedge clk); #1; end
        checks++; if (done_cnt != d0 || HTRANS !== 2'b00) begin errors++;
            $display("FAIL reset_no_irq: done_pulses=%0d HTRANS=%b want 0 00", done_cnt - d0, HTRANS); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_wait_states();
        test_fixed_dst();
        test_error();
        test_zero_len_and_busy_start();
        test_abort();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
